// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL opcode encodings and the registered D-channel response record.
package tl_ul_pkg;

    localparam logic [2:0] A_PUT_FULL        = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] A_GET             = 3'd4;
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    // d_source is carried separately because its width is a module parameter
    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } d_rsp_t;

endpackage

// File: rtl/tl_ul_scratch_mem.sv
// Flop-based scratch word array: byte-lane write enables, asynchronous read, no reset.
module tl_ul_scratch_mem #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [3:0]            wmask,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (we && wmask[b]) begin
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/tl_ul_scratch_responder.sv
// TileLink-UL manager responder: legality decode, scratch array access and a
// one-entry registered D-channel response buffer.
module tl_ul_scratch_responder
    import tl_ul_pkg::*;
#(
    parameter logic [29:0] BASE       = 30'h0000_1000,
    parameter int          DEPTH_LOG2 = 6,
    parameter int          SOURCE_W   = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [1:0]          a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [29:0]         a_address,
    input  logic [3:0]          a_mask,
    input  logic [31:0]         a_data,
    input  logic                a_corrupt,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [1:0]          d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic                d_sink,
    output logic                d_denied,
    output logic [31:0]         d_data,
    output logic                d_corrupt
);

    localparam logic [29:0] LIMIT = BASE + 30'(4 << DEPTH_LOG2);

    logic                  fire;
    logic                  is_get;
    logic                  is_put;
    logic                  misaligned;
    logic                  in_range;
    logic                  denied;
    logic [29:0]           offset;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           rdata;
    logic                  unused_bits;
    d_rsp_t                rsp_q;
    d_rsp_t                rsp_next;
    logic [SOURCE_W-1:0]   source_q;
    logic                  valid_q;

    assign a_ready = !valid_q || d_ready;
    assign fire    = a_valid && a_ready;

    assign is_get   = (a_opcode == A_GET);
    assign is_put   = (a_opcode == A_PUT_FULL) || (a_opcode == A_PUT_PARTIAL);
    assign in_range = (a_address >= BASE) && (a_address < LIMIT);
    assign offset   = a_address - BASE;
    assign idx      = offset[DEPTH_LOG2+1:2];

    always_comb begin
        misaligned = 1'b0;
        case (a_size)
            2'd1:    misaligned = a_address[0];
            2'd2:    misaligned = |a_address[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign denied = !(is_get || is_put) || (a_param != 3'd0) || (a_size == 2'd3)
                    || misaligned || !in_range;

    // Corrupt write data is still committed; the flag only travels with the beat.
    assign unused_bits = ^{a_corrupt, offset[29:DEPTH_LOG2+2], offset[1:0]};

    tl_ul_scratch_mem #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clock (clock),
        .we    (fire && is_put && !denied && !reset),
        .idx   (idx),
        .wmask (a_mask),
        .wdata (a_data),
        .rdata (rdata)
    );

    always_comb begin
        rsp_next        = '0;
        rsp_next.size   = a_size;
        rsp_next.denied = denied;
        case (a_opcode)
            A_GET, 3'd2, 3'd3: rsp_next.opcode = D_ACCESS_ACK_DATA;
            default:           rsp_next.opcode = D_ACCESS_ACK;
        endcase
        if (is_get && !denied) begin
            rsp_next.data = rdata;
        end else if (denied && rsp_next.opcode == D_ACCESS_ACK_DATA) begin
            rsp_next.corrupt = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= 1'b0;
            rsp_q    <= '0;
            source_q <= '0;
        end else if (fire) begin
            valid_q  <= 1'b1;
            rsp_q    <= rsp_next;
            source_q <= a_source;
        end else if (d_ready) begin
            valid_q  <= 1'b0;
        end
    end

    assign d_valid   = valid_q;
    assign d_opcode  = rsp_q.opcode;
    assign d_param   = 2'd0;
    assign d_size    = rsp_q.size;
    assign d_source  = source_q;
    assign d_sink    = 1'b0;
    assign d_denied  = rsp_q.denied;
    assign d_data    = rsp_q.data;
    assign d_corrupt = rsp_q.corrupt;

endmodule

// File: tb/tb_tl_ul_scratch_responder.sv
// Directed vector table plus back-pressure, back-to-back and reset sequences.
module tb_tl_ul_scratch_responder;
    import tl_ul_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [9:0]  a_source;
    logic [29:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [9:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    tl_ul_scratch_responder dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data), .a_corrupt(a_corrupt),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
        .d_data(d_data), .d_corrupt(d_corrupt)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  param;
        logic [1:0]  size;
        logic [9:0]  src;
        logic [29:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        corrupt;
        logic [2:0]  e_op;
        logic        e_den;
        logic [31:0] e_data;
        logic        e_cor;
        logic        chk_cor;
    } vec_t;

    localparam int NV = 18;
    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] param, input logic [1:0] size,
                         input logic [9:0] src, input logic [29:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic corrupt);
        a_valid   = 1'b1;
        a_opcode  = op;
        a_param   = param;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_corrupt = corrupt;
    endtask

    task automatic idle();
        a_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         op  par sz  src     addr          mask  data          cor  e_op e_den e_data        e_cor chk
        vec[0]  = '{3'd0, 3'd0, 2'd2, 10'h3A5, 30'h1004, 4'hF, 32'hDEADBEEF, 1'b0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b1};
        vec[1]  = '{3'd4, 3'd0, 2'd2, 10'h001, 30'h1004, 4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1};
        vec[2]  = '{3'd1, 3'd0, 2'd2, 10'h002, 30'h1004, 4'h2, 32'h00005500, 1'b0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b1};
        vec[3]  = '{3'd4, 3'd0, 2'd2, 10'h003, 30'h1004, 4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'hDEAD55EF, 1'b0, 1'b1};
        vec[4]  = '{3'd4, 3'd0, 2'd2, 10'h004, 30'h1100, 4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 32'h0,        1'b1, 1'b1};
        vec[5]  = '{3'd0, 3'd0, 2'd2, 10'h005, 30'h0FFC, 4'hF, 32'h12345678, 1'b0, 3'd0, 1'b1, 32'h0,        1'b0, 1'b1};
        vec[6]  = '{3'd4, 3'd0, 2'd2, 10'h006, 30'h1004, 4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'hDEAD55EF, 1'b0, 1'b1};
        vec[7]  = '{3'd4, 3'd0, 2'd2, 10'h007, 30'h1002, 4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 32'h0,        1'b1, 1'b1};
        vec[8]  = '{3'd2, 3'd0, 2'd2, 10'h008, 30'h1008, 4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 32'h0,        1'b0, 1'b0};
        vec[9]  = '{3'd4, 3'd1, 2'd2, 10'h009, 30'h1004, 4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 32'h0,        1'b1, 1'b1};
        vec[10] = '{3'd4, 3'd0, 2'd3, 10'h00A, 30'h1000, 4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 32'h0,        1'b1, 1'b1};
        vec[11] = '{3'd0, 3'd0, 2'd2, 10'h00B, 30'h10FC, 4'hF, 32'hA5A5A5A5, 1'b0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b1};
        vec[12] = '{3'd4, 3'd0, 2'd2, 10'h00C, 30'h10FC, 4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1};
        vec[13] = '{3'd4, 3'd0, 2'd0, 10'h00D, 30'h10FD, 4'h2, 32'h0,        1'b0, 3'd1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1};
        vec[14] = '{3'd4, 3'd0, 2'd1, 10'h00E, 30'h10FD, 4'h3, 32'h0,        1'b0, 3'd1, 1'b1, 32'h0,        1'b1, 1'b1};
        vec[15] = '{3'd7, 3'd0, 2'd2, 10'h00F, 30'h1004, 4'hF, 32'h0,        1'b0, 3'd0, 1'b1, 32'h0,        1'b0, 1'b0};
        vec[16] = '{3'd0, 3'd0, 2'd2, 10'h010, 30'h1008, 4'hF, 32'h11112222, 1'b1, 3'd0, 1'b0, 32'h0,        1'b0, 1'b1};
        vec[17] = '{3'd4, 3'd0, 2'd2, 10'h011, 30'h1008, 4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'h11112222, 1'b0, 1'b1};

        reset = 1'b1;
        d_ready = 1'b1;
        idle();
        drive(3'd0, 3'd0, 2'd0, 10'h0, 30'h0, 4'h0, 32'h0, 1'b0);
        idle();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_d_valid",   32'(d_valid),   32'h0);
        check("rst_d_opcode",  32'(d_opcode),  32'h0);
        check("rst_d_size",    32'(d_size),    32'h0);
        check("rst_d_source",  32'(d_source),  32'h0);
        check("rst_d_denied",  32'(d_denied),  32'h0);
        check("rst_d_data",    d_data,         32'h0);
        check("rst_d_corrupt", 32'(d_corrupt), 32'h0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("post_rst_a_ready", 32'(a_ready), 32'h1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            drive(vec[i].op, vec[i].param, vec[i].size, vec[i].src, vec[i].addr,
                  vec[i].mask, vec[i].data, vec[i].corrupt);
            check($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'h1);
            @(posedge clock);
            #1 idle();
            @(negedge clock);
            check($sformatf("v%0d_d_valid", i),  32'(d_valid),  32'h1);
            check($sformatf("v%0d_d_opcode", i), 32'(d_opcode), 32'(vec[i].e_op));
            check($sformatf("v%0d_d_denied", i), 32'(d_denied), 32'(vec[i].e_den));
            check($sformatf("v%0d_d_source", i), 32'(d_source), 32'(vec[i].src));
            check($sformatf("v%0d_d_size", i),   32'(d_size),   32'(vec[i].size));
            check($sformatf("v%0d_d_data", i),   d_data,        vec[i].e_data);
            check($sformatf("v%0d_d_param_sink", i), 32'({d_param, d_sink}), 32'h0);
            if (vec[i].chk_cor)
                check($sformatf("v%0d_d_corrupt", i), 32'(d_corrupt), 32'(vec[i].e_cor));
        end

        // Back-pressure: hold d_ready low for 3 cycles with a second request waiting.
        @(negedge clock);
        d_ready = 1'b0;
        drive(A_GET, 3'd0, 2'd2, 10'h111, 30'h1004, 4'hF, 32'h0, 1'b0);
        @(posedge clock);
        #1 drive(A_GET, 3'd0, 2'd2, 10'h222, 30'h10FC, 4'hF, 32'h0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check($sformatf("bp%0d_a_ready", c),  32'(a_ready),  32'h0);
            check($sformatf("bp%0d_d_valid", c),  32'(d_valid),  32'h1);
            check($sformatf("bp%0d_d_source", c), 32'(d_source), 32'h111);
            check($sformatf("bp%0d_d_data", c),   d_data,        32'hDEAD55EF);
            check($sformatf("bp%0d_d_opcode", c), 32'(d_opcode), 32'(D_ACCESS_ACK_DATA));
            if (c < 2) @(posedge clock);
        end
        d_ready = 1'b1;
        #1 check("bp_release_a_ready", 32'(a_ready), 32'h1);
        @(posedge clock);
        #1 idle();
        @(negedge clock);
        check("bp_next_d_valid",  32'(d_valid),  32'h1);
        check("bp_next_d_source", 32'(d_source), 32'h222);
        check("bp_next_d_data",   d_data,        32'hA5A5A5A5);
        @(posedge clock);
        @(negedge clock);
        check("bp_drain_d_valid", 32'(d_valid), 32'h0);

        // Back-to-back: write then read the same word in consecutive fires.
        drive(A_PUT_FULL, 3'd0, 2'd2, 10'h005, 30'h1010, 4'hF, 32'hCAFEF00D, 1'b0);
        @(posedge clock);
        #1 drive(A_GET, 3'd0, 2'd2, 10'h006, 30'h1010, 4'hF, 32'h0, 1'b0);
        @(negedge clock);
        check("b2b0_d_source", 32'(d_source), 32'h005);
        check("b2b0_d_opcode", 32'(d_opcode), 32'(D_ACCESS_ACK));
        check("b2b0_a_ready",  32'(a_ready),  32'h1);
        @(posedge clock);
        #1 idle();
        @(negedge clock);
        check("b2b1_d_valid",  32'(d_valid),  32'h1);
        check("b2b1_d_source", 32'(d_source), 32'h006);
        check("b2b1_d_data",   d_data,        32'hCAFEF00D);

        // Reset while a response is pending; scratch contents must survive.
        @(negedge clock);
        d_ready = 1'b0;
        drive(A_GET, 3'd0, 2'd2, 10'h077, 30'h1008, 4'hF, 32'h0, 1'b0);
        @(posedge clock);
        #1 idle();
        @(negedge clock);
        check("rp_pending_d_valid", 32'(d_valid), 32'h1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rp_d_valid", 32'(d_valid), 32'h0);
        check("rp_d_data",  d_data,       32'h0);
        reset = 1'b0;
        d_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rp_a_ready", 32'(a_ready), 32'h1);
        drive(A_GET, 3'd0, 2'd2, 10'h078, 30'h1008, 4'hF, 32'h0, 1'b0);
        @(posedge clock);
        #1 idle();
        @(negedge clock);
        check("rp_get_d_valid", 32'(d_valid), 32'h1);
        check("rp_get_d_data",  d_data,       32'h11112222);
        check("rp_get_d_data2", 32'(d_denied), 32'h0);

        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
